// File: rtl/imem_prefetch_bridge_pkg.sv
// Shared word/address definitions for the instruction-fetch prefetch bridge.
// Also classifies what fetch is asking for in a given cycle.
package imem_prefetch_bridge_pkg;

  localparam int          RISCV_ADDR_WIDTH = 32;
  localparam int          RISCV_WORD_WIDTH = 32;
  localparam logic [31:0] RISCV_WORD_INC   = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_HIT,
    FETCH_WAIT,
    FETCH_REDIRECT
  } fetch_case_e;

  function automatic logic [RISCV_ADDR_WIDTH-1:0] word_align(input logic [RISCV_ADDR_WIDTH-1:0] a);
    return {a[RISCV_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Response FIFO for prefetched instruction words; clear wins over push and pop.
// Head is read combinationally; push and pop in one cycle leave the count unchanged.
module imem_resp_fifo
  import imem_prefetch_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_i,
  input  logic                        push_i,
  input  logic [RISCV_WORD_WIDTH-1:0] push_data_i,
  input  logic                        pop_i,
  output logic [RISCV_WORD_WIDTH-1:0] head_o,
  output logic [AW:0]                 count_o
);

  logic [RISCV_WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [AW:0]                 count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/imem_prefetch_bridge.sv
// Sequential instruction prefetcher between fetch and a pipelined in-order bus.
// Issue is credit-limited by FIFO space and outstanding requests; redirects flush and discard.
module imem_prefetch_bridge
  import imem_prefetch_bridge_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_ready_o,
  output logic [31:0] imem_rdata_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic          stream_valid_q, stream_valid_d;
  logic [31:0]   stream_addr_q, stream_addr_d;
  logic [31:0]   next_issue_q, next_issue_d;
  logic [OW-1:0] live_cnt_q, live_cnt_d;
  logic [OW-1:0] discard_cnt_q, discard_cnt_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;

  fetch_case_e   fcase;
  logic          granted, resp_live, resp_drop;
  logic          fifo_clear, fifo_push, fifo_pop;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;

  imem_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (fifo_clear),
    .push_i      (fifo_push),
    .push_data_i (bus_rdata_i),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign bus_req_o = stream_valid_q
                  && (32'(fifo_count) + 32'(live_cnt_q) < 32'(DEPTH))
                  && (32'(live_cnt_q) + 32'(discard_cnt_q) < 32'(MAX_OUTSTANDING));
  assign bus_addr_o = next_issue_q;

  always_comb begin
    fcase = FETCH_IDLE;
    if (imem_valid_i) begin
      if (!stream_valid_q || (imem_addr_i[31:2] != stream_addr_q[31:2])) fcase = FETCH_REDIRECT;
      else if (fifo_count != '0)                                          fcase = FETCH_HIT;
      else                                                                fcase = FETCH_WAIT;
    end
  end

  always_comb begin
    granted        = bus_req_o && bus_gnt_i;
    resp_drop      = bus_rvalid_i && (discard_cnt_q != '0);
    resp_live      = bus_rvalid_i && (discard_cnt_q == '0);
    fifo_clear     = (fcase == FETCH_REDIRECT);
    fifo_push      = resp_live && (fcase != FETCH_REDIRECT);
    fifo_pop       = (fcase == FETCH_HIT);
    stream_valid_d = stream_valid_q;
    stream_addr_d  = stream_addr_q;
    next_issue_d   = next_issue_q;
    live_cnt_d     = live_cnt_q;
    discard_cnt_d  = discard_cnt_q;
    ready_d        = (fcase == FETCH_HIT);
    rdata_d        = (fcase == FETCH_HIT) ? fifo_head : rdata_q;
    if (fcase == FETCH_REDIRECT) begin
      stream_valid_d = 1'b1;
      stream_addr_d  = word_align(imem_addr_i);
      next_issue_d   = word_align(imem_addr_i);
      live_cnt_d     = '0;
      // Any response this cycle retires one outstanding request, live or stale.
      discard_cnt_d  = discard_cnt_q + live_cnt_q + OW'(granted) - OW'(bus_rvalid_i);
    end else begin
      if (fcase == FETCH_HIT) stream_addr_d = stream_addr_q + RISCV_WORD_INC;
      if (granted)            next_issue_d  = next_issue_q + RISCV_WORD_INC;
      live_cnt_d    = live_cnt_q + OW'(granted) - OW'(resp_live);
      discard_cnt_d = discard_cnt_q - OW'(resp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stream_valid_q <= 1'b0;
      stream_addr_q  <= '0;
      next_issue_q   <= '0;
      live_cnt_q     <= '0;
      discard_cnt_q  <= '0;
      ready_q        <= 1'b0;
      rdata_q        <= '0;
    end else begin
      stream_valid_q <= stream_valid_d;
      stream_addr_q  <= stream_addr_d;
      next_issue_q   <= next_issue_d;
      live_cnt_q     <= live_cnt_d;
      discard_cnt_q  <= discard_cnt_d;
      ready_q        <= ready_d;
      rdata_q        <= rdata_d;
    end
  end

  assign imem_ready_o = ready_q;
  assign imem_rdata_o = rdata_q;

  a_fifo_credit: assert property (@(posedge clk) disable iff (!rst_n)
    32'(fifo_count) + 32'(live_cnt_q) <= 32'(DEPTH));
  a_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    32'(live_cnt_q) + 32'(discard_cnt_q) <= 32'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_imem_prefetch_bridge.sv
// Bench for imem_prefetch_bridge: randomized in-order bus model plus a memory function;
// every ready word must equal mem[] of the address fetch presented the cycle before.
module tb_imem_prefetch_bridge;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_valid_i = 1'b0;
  logic [31:0] imem_addr_i = '0;
  logic        imem_ready_o;
  logic [31:0] imem_rdata_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  imem_prefetch_bridge #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_valid_i (imem_valid_i),
    .imem_addr_i  (imem_addr_i),
    .imem_ready_o (imem_ready_o),
    .imem_rdata_o (imem_rdata_o),
    .bus_req_o    (bus_req_o),
    .bus_addr_o   (bus_addr_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_ready  = 0;
  int gnt_pct  = 100;
  int lat_min  = 1;
  int lat_max  = 1;
  int last_due = -1;
  int max_q    = 0;

  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] grant_log[$];

  logic        prev_valid = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] fetch_addr = '0;
  logic        last_gnt, last_rv;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // One fetch/bus cycle: check what the DUT shows now, then drive this cycle's inputs.
  task automatic tick(input bit v, input bit jump, input logic [31:0] jaddr);
    int due;
    if (imem_ready_o === 1'b1) begin
      n_checks++;
      if (!prev_valid || imem_rdata_o !== mem(prev_addr)) begin
        n_fail++;
        $display("FAIL ready_data cyc=%0d prev_valid=%0b addr=%h got=%h want=%h",
                 cyc, prev_valid, prev_addr, imem_rdata_o, mem(prev_addr));
      end
      n_ready++;
      fetch_addr = prev_addr + 32'd4;
    end
    if (jump) fetch_addr = {jaddr[31:2], 2'b00};
    last_rv = 1'b0;
    bus_rdata_i = '0;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      last_rv = 1'b1;
      bus_rdata_i = mem(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    bus_rvalid_i = last_rv;
    bus_gnt_i = (int'($urandom_range(99)) < gnt_pct);
    last_gnt = bus_gnt_i && bus_req_o;
    if (last_gnt) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q_addr.push_back(bus_addr_o);
      q_due.push_back(due);
      grant_log.push_back(bus_addr_o);
    end
    if (q_addr.size() > max_q) max_q = q_addr.size();
    n_checks++;
    if (q_addr.size() > MAXO) begin
      n_fail++;
      $display("FAIL outstanding cyc=%0d got=%0d max=%0d", cyc, q_addr.size(), MAXO);
    end
    imem_valid_i = v;
    imem_addr_i  = fetch_addr;
    prev_valid   = v;
    prev_addr    = fetch_addr;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic bus_forget();
    q_addr.delete();
    q_due.delete();
    last_due = -1;
    prev_valid = 1'b0;
    imem_valid_i = 1'b0;
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (imem_ready_o !== 1'b0 || imem_rdata_o !== 32'h0 || bus_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs ready=%b rdata=%h req=%b want 0/0/0", imem_ready_o, imem_rdata_o, bus_req_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (bus_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset got req=%b want 0", bus_req_o);
      end
    end
  endtask

  task automatic test_sequential();
    int rc, first, cnt;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    grant_log.delete();
    rc = cyc; first = -1; cnt = 0;
    tick(1'b1, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 20; i++) begin
      if (imem_ready_o === 1'b1) begin
        if (first < 0) first = cyc;
        if (cyc <= rc + 19) cnt++;
      end
      tick(1'b1, 1'b0, 32'h0);
    end
    n_checks++;
    if (first != rc + 4) begin
      n_fail++;
      $display("FAIL first_ready_latency got=%0d want=%0d", first - rc, 4);
    end
    n_checks++;
    if (cnt != 16) begin
      n_fail++;
      $display("FAIL full_rate got=%0d want=16", cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (grant_log[i] !== 32'h100 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL seq_bus_addr[%0d] got=%h want=%h", i, grant_log[i], 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_latency3();
    int r0;
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    max_q = 0; r0 = n_ready;
    tick(1'b1, 1'b1, 32'h0);
    repeat (40) tick(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (max_q != MAXO) begin
      n_fail++;
      $display("FAIL lat3_max_outstanding got=%0d want=%0d", max_q, MAXO);
    end
    n_checks++;
    if (n_ready - r0 < 10) begin
      n_fail++;
      $display("FAIL lat3_progress got=%0d want>=10", n_ready - r0);
    end
  endtask

  task automatic test_redirect_flush();
    bit done;
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    tick(1'b1, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 30 && !(q_addr.size() == 2 && fetch_addr >= 32'h204); i++)
      tick(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (q_addr.size() != 2) begin
      n_fail++;
      $display("FAIL flush_setup in_flight got=%0d want=2", q_addr.size());
    end
    tick(1'b1, 1'b1, 32'h0000_1000);
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (imem_ready_o === 1'b1) begin
        done = 1'b1;
        n_checks++;
        if (imem_rdata_o !== mem(32'h1000)) begin
          n_fail++;
          $display("FAIL flush_first_word got=%h want=%h (stale %h)", imem_rdata_o, mem(32'h1000), mem(32'h208));
        end
      end
      tick(1'b1, 1'b0, 32'h0);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL flush_timeout got=no_ready want=ready");
    end
  endtask

  task automatic test_redirect_same_cycle();
    bit found, done;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    repeat (5) tick(1'b1, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus_req_o === 1'b1 && q_addr.size() > 0 && q_due[0] <= cyc) found = 1'b1;
      else tick(1'b1, 1'b0, 32'h0);
    end
    tick(1'b1, 1'b1, 32'h0000_3000);
    n_checks++;
    if (!(last_gnt && last_rv)) begin
      n_fail++;
      $display("FAIL same_cycle_setup got gnt=%b rv=%b want 1/1", last_gnt, last_rv);
    end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (imem_ready_o === 1'b1) begin
        done = 1'b1;
        n_checks++;
        if (imem_rdata_o !== mem(32'h3000)) begin
          n_fail++;
          $display("FAIL same_cycle_first_word got=%h want=%h", imem_rdata_o, mem(32'h3000));
        end
      end
      tick(1'b1, 1'b0, 32'h0);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL same_cycle_timeout got=no_ready want=ready");
    end
    repeat (10) tick(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_idle_prefetch();
    int rs, first, last, cnt;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    repeat (10) tick(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (bus_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_req_drop got=%b want=0", bus_req_o);
    end
    gnt_pct = 0;
    rs = cyc; first = -1; last = -1; cnt = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (imem_ready_o === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        cnt++;
      end
      tick(1'b1, 1'b0, 32'h0);
    end
    n_checks++;
    if (cnt != DEPTH || first != rs + 1 || last != rs + DEPTH) begin
      n_fail++;
      $display("FAIL idle_burst got cnt=%0d first=%0d last=%0d want cnt=%0d first=1 last=%0d",
               cnt, first - rs, last - rs, DEPTH, DEPTH);
    end
    gnt_pct = 100;
    repeat (5) tick(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 2; gnt_pct = 70;
    tick(1'b1, 1'b1, 32'hFFFF_FFF8);
    grant_log.delete();
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) tick(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (grant_log.size() < 4) begin
      n_fail++;
      $display("FAIL wrap_timeout got=%0d grants want=4", grant_log.size());
    end else begin
      n_checks++;
      if (grant_log[0] !== 32'hFFFF_FFF8 || grant_log[1] !== 32'hFFFF_FFFC ||
          grant_log[2] !== 32'h0 || grant_log[3] !== 32'h4) begin
        n_fail++;
        $display("FAIL wrap_addrs got=%h %h %h %h want=fffffff8 fffffffc 0 4",
                 grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
      end
    end
    repeat (10) tick(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_reset_midflight();
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    tick(1'b1, 1'b1, 32'h0000_4000);
    repeat (6) tick(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (q_addr.size() == 0) begin
      n_fail++;
      $display("FAIL rst_setup in_flight got=0 want>0");
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_ready_o !== 1'b0 || imem_rdata_o !== 32'h0 || bus_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset ready=%b rdata=%h req=%b want 0/0/0", imem_ready_o, imem_rdata_o, bus_req_o);
    end
    bus_forget();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (bus_req_o !== 1'b0 || imem_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle got req=%b ready=%b want 0/0", bus_req_o, imem_ready_o);
      end
    end
    lat_min = 1; lat_max = 1;
    tick(1'b1, 1'b1, 32'h0000_5000);
    repeat (12) tick(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    int r0;
    logic [31:0] ja;
    r0 = n_ready;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        lat_min = int'($urandom_range(2, 1));
        lat_max = lat_min + int'($urandom_range(3));
        gnt_pct = int'($urandom_range(100, 40));
      end
      ja = $urandom;
      if ($urandom_range(3) == 0) ja = 32'hFFFF_FFF0 | (ja & 32'hC);
      tick($urandom_range(9) != 0, $urandom_range(29) == 0, ja);
    end
    n_checks++;
    if (n_ready - r0 < 100) begin
      n_fail++;
      $display("FAIL random_progress got=%0d want>=100", n_ready - r0);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_latency3();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_idle_prefetch();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
